// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
//   32-entry general-purpose register file for a single-cycle RV32I core.
//   Two combinational read ports supply rs1/rs2 operands. One synchronous write
//   port takes the writeback result. Register x0 is hardwired to zero.
//
// Ports
//   clk       in   system clock; writes happen on its rising edge
//   rst       in   asynchronous, active-low reset; clears every entry at once
//   rs1_addr  in   read port 1 register index
//   rs2_addr  in   read port 2 register index
//   rd_addr   in   write port register index
//   rd_wren   in   write enable, active-high
//   rd_data   in   write data
//   rs1_data  out  contents of register rs1_addr (zero-latency)
//   rs2_data  out  contents of register rs2_addr (zero-latency)
// -----------------------------------------------------------------------------
module reg_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] rs1_addr,
   input  logic [ADDR_WIDTH-1:0] rs2_addr,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic                  rd_wren,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic [DATA_WIDTH-1:0] rs1_data,
   output logic [DATA_WIDTH-1:0] rs2_data
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] register_array [DEPTH];

   // NOTE: this storage is deliberately built from resettable flops rather than
   // a RAM macro: every entry must read a defined zero the instant reset is
   // asserted, which a RAM cannot provide.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            register_array[i] <= '0;
         end
      end else if (rd_wren && (rd_addr != '0)) begin
         // NOTE: non-blocking assignment so a same-cycle read still sees the
         // old value until after the edge (no write-to-read bypass).
         register_array[rd_addr] <= rd_data;
      end
   end

   // Entry 0 is only ever reset, so reading it already yields zero; the
   // explicit select keeps x0 at zero even if the array were ever corrupted.
   assign rs1_data = (rs1_addr == '0) ? '0 : register_array[rs1_addr];
   assign rs2_data = (rs2_addr == '0) ? '0 : register_array[rs2_addr];

endmodule

// File: tb/tb_reg_file.sv
// -----------------------------------------------------------------------------
// tb_reg_file
//   Self-checking bench for reg_file: a table of directed write/read vectors,
//   hand-written sequences for reset, enable-low and same-cycle corner cases,
//   and a random write/read sweep against an array reference model.
// -----------------------------------------------------------------------------
module tb_reg_file;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] rs1_addr, rs2_addr, rd_addr;
   logic          rd_wren;
   logic [DW-1:0] rd_data;
   logic [DW-1:0] rs1_data, rs2_data;

   int errors = 0;
   int checks = 0;

   // Reference model: plain array, writes to index 0 are dropped.
   logic [DW-1:0] model [32];

   typedef struct {
      logic          wren;
      logic [AW-1:0] waddr;
      logic [DW-1:0] wdata;
      logic [AW-1:0] a1;
      logic [AW-1:0] a2;
      logic [DW-1:0] e1;
      logic [DW-1:0] e2;
   } vec_t;

   vec_t vecs [8];

   reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk      (clk),
      .rst      (rst),
      .rs1_addr (rs1_addr),
      .rs2_addr (rs2_addr),
      .rd_addr  (rd_addr),
      .rd_wren  (rd_wren),
      .rd_data  (rd_data),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [DW-1:0] actual,
                        input logic [DW-1:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) model[i] = '0;
   endtask

   // Drive a write at the falling edge, let the rising edge commit it, then
   // step 1 time unit past the edge so outputs are stable for checking.
   task automatic do_write(input logic wren, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data);
      @(negedge clk);
      rd_wren = wren;
      rd_addr = addr;
      rd_data = data;
      @(posedge clk);
      if (wren && addr != 0) model[addr] = data;
      #1;
   endtask

   initial begin
      vecs[0] = '{1'b1, 5'd7,  32'h1234_5678, 5'd7,  5'd0,  32'h1234_5678, 32'h0000_0000};
      vecs[1] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd7,  5'd0,  32'h1234_5678, 32'h0000_0000};
      vecs[2] = '{1'b1, 5'd3,  32'hA5A5_A5A5, 5'd3,  5'd3,  32'hA5A5_A5A5, 32'hA5A5_A5A5};
      vecs[3] = '{1'b0, 5'd3,  32'h0000_0000, 5'd3,  5'd7,  32'hA5A5_A5A5, 32'h1234_5678};
      vecs[4] = '{1'b1, 5'd31, 32'h8000_0001, 5'd31, 5'd3,  32'h8000_0001, 32'hA5A5_A5A5};
      vecs[5] = '{1'b1, 5'd31, 32'h7FFF_FFFE, 5'd31, 5'd31, 32'h7FFF_FFFE, 32'h7FFF_FFFE};
      vecs[6] = '{1'b1, 5'd1,  32'hCAFE_F00D, 5'd1,  5'd0,  32'hCAFE_F00D, 32'h0000_0000};
      vecs[7] = '{1'b0, 5'd1,  32'h0BAD_0BAD, 5'd1,  5'd7,  32'hCAFE_F00D, 32'h1234_5678};

      rst      = 1'b1;
      rd_wren  = 1'b0;
      rd_addr  = '0;
      rd_data  = '0;
      rs1_addr = '0;
      rs2_addr = '0;
      model_clear();

      // ---- power-on reset, checked before any clock edge ----
      #1 rst = 1'b0;
      #1;
      check("por_entry5", dut.register_array[5], 32'h0);
      check("por_entry31", dut.register_array[31], 32'h0);
      rs1_addr = 5'd5;
      rs2_addr = 5'd31;
      #1;
      check("por_rs1", rs1_data, 32'h0);
      check("por_rs2", rs2_data, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;

      // ---- table-driven directed vectors ----
      for (int i = 0; i < 8; i++) begin
         rs1_addr = vecs[i].a1;
         rs2_addr = vecs[i].a2;
         do_write(vecs[i].wren, vecs[i].waddr, vecs[i].wdata);
         check($sformatf("vec%0d_rs1", i), rs1_data, vecs[i].e1);
         check($sformatf("vec%0d_rs2", i), rs2_data, vecs[i].e2);
      end
      check("tbl_arr7", dut.register_array[7], 32'h1234_5678);
      check("tbl_arr0", dut.register_array[0], 32'h0);

      // ---- write enable low for several edges ----
      rs1_addr = 5'd3;
      repeat (4) do_write(1'b0, 5'd3, 32'h0);
      check("wren_low_x3", rs1_data, 32'hA5A5_A5A5);

      // ---- same-cycle read/write: old value before the edge, new after ----
      do_write(1'b1, 5'd9, 32'h1111_1111);
      @(negedge clk);
      rs1_addr = 5'd9;
      rd_wren  = 1'b1;
      rd_addr  = 5'd9;
      rd_data  = 32'h2222_2222;
      #1;
      check("rw_before_edge", rs1_data, 32'h1111_1111);
      @(posedge clk);
      #1;
      check("rw_after_edge", rs1_data, 32'h2222_2222);

      // ---- reset between edges clears at once; reset dominates a write ----
      do_write(1'b1, 5'd5, 32'hDEAD_BEEF);
      rs1_addr = 5'd5;
      #1;
      check("preload_x5", rs1_data, 32'hDEAD_BEEF);
      @(negedge clk);
      rd_wren = 1'b1;
      rd_addr = 5'd5;
      rd_data = 32'h5555_AAAA;
      #2 rst = 1'b0;
      #1;
      check("midrst_arr5", dut.register_array[5], 32'h0);
      check("midrst_rs1", rs1_data, 32'h0);
      check("midrst_arr9", dut.register_array[9], 32'h0);
      @(posedge clk);
      #1;
      check("rst_dominates_write", dut.register_array[5], 32'h0);
      // Deassert between edges with the write still pending: first rising edge
      // with rst high commits it.
      #2 rst = 1'b1;
      #1;
      check("post_rst_prewrite", rs1_data, 32'h0);
      @(posedge clk);
      #1;
      check("post_rst_first_write", rs1_data, 32'h5555_AAAA);
      model_clear();
      model[5] = 32'h5555_AAAA;

      // ---- random sweep against the model ----
      for (int i = 0; i < 100; i++) begin
         do_write(1'b1, AW'($urandom_range(0, 31)), $urandom);
      end
      @(negedge clk);
      rd_wren = 1'b0;
      for (int i = 0; i < 100; i++) begin
         logic [AW-1:0] a1, a2;
         a1 = (i % 10 == 0) ? 5'd0 : AW'($urandom_range(0, 31));
         a2 = AW'($urandom_range(0, 31));
         rs1_addr = a1;
         rs2_addr = a2;
         #1;
         check($sformatf("rand_rs1[%0d]", a1), rs1_data, model[a1]);
         check($sformatf("rand_rs2[%0d]", a2), rs2_data, model[a2]);
         check($sformatf("rand_arr[%0d]", a1), dut.register_array[a1], model[a1]);
      end
      check("rand_arr0", dut.register_array[0], 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 32-entry x 32-bit general-purpose register file for the single-cycle RV32I core.
- Two asynchronous (combinational) read ports feed operands rs1/rs2 to the ALU and branch unit.
- One synchronous write port takes the writeback result rd.
- Register x0 is hardwired to zero, per the RISC-V convention.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, width of the register index; depth = 2**ADDR_WIDTH = 32 entries.

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- rst  input  1  asynchronous, active-low reset; 0 = reset asserted.
- rs1_addr  input  ADDR_WIDTH  read port 1 register index.
- rs2_addr  input  ADDR_WIDTH  read port 2 register index.
- rd_addr  input  ADDR_WIDTH  write port register index.
- rd_wren  input  1  write enable, active-high.
- rd_data  input  DATA_WIDTH  write data.
- rs1_data  output  DATA_WIDTH  contents of register rs1_addr.
- rs2_data  output  DATA_WIDTH  contents of register rs2_addr.

Behaviour:
- Storage:
  - Internal array named register_array, 32 entries x DATA_WIDTH bits.
  - The name is fixed so benches can reference register_array[i] hierarchically.
- Reset:
  - While rst = 0, all 32 entries clear to 32'h0000_0000 immediately, without waiting for a clock edge.
  - Reset dominates any write in progress.
  - rs1_data and rs2_data therefore read 0 during reset.
- Write:
  - On the rising edge of clk with rst = 1, rd_wren = 1 and rd_addr != 0: register_array[rd_addr] <= rd_data.
  - The value is visible in the array and on the read ports immediately after that edge (write latency 1 edge).
  - rd_wren = 0: no entry changes.
  - rd_addr = 0: the write is silently discarded and register_array[0] stays 0 permanently.
- Read:
  - Purely combinational, zero latency.
  - rs1_data = register_array[rs1_addr] and rs2_data = register_array[rs2_addr].
  - Address 0 always returns 0.
  - Both ports are independent; rs1_addr = rs2_addr is legal and returns identical data on both.
- No write-to-read bypass:
  - When reading and writing the same index in the same cycle, the read returns the old value until the clock edge.
  - After the edge, the read returns the new value. This matches single-cycle timing.
- Back-to-back writes:
  - One write per edge, no stall or hazard logic.
  - Consecutive writes to the same index keep the last one.
- Reset mid-operation:
  - Asserting rst between clock edges clears the array at once.
  - The first write after deassertion occurs at the first rising edge with rst = 1.
- No X propagation: every entry has a defined value after reset.

Test Plan:
- Reset:
  - Preload x5 = 32'hDEAD_BEEF, then pulse rst = 0 between edges.
  - Required: register_array[5] = 0 immediately, before the next clock edge; reading rs1_addr = 5 gives 0.
- Basic write/read:
  - With rst = 1, rd_wren = 1, rd_addr = 7, rd_data = 32'h1234_5678, apply one clock edge.
  - Required: register_array[7] = 32'h1234_5678; rs1_addr = 7 gives rs1_data = 32'h1234_5678 combinationally.
- x0 hardwired:
  - Write rd_addr = 0, rd_data = 32'hFFFF_FFFF.
  - Required: register_array[0] = 0 and rs2_data = 0 when rs2_addr = 0.
- Write enable low:
  - With x3 = 32'hA5A5_A5A5, drive rd_wren = 0, rd_addr = 3, rd_data = 32'h0 for several edges.
  - Required: x3 still reads 32'hA5A5_A5A5.
- Same-cycle read/write:
  - With x9 = 32'h1111_1111, set rs1_addr = 9 and write x9 <= 32'h2222_2222.
  - Required: rs1_data = 32'h1111_1111 before the edge and 32'h2222_2222 after it.
- Random sweep:
  - Run 100 random writes (address 0-31, random data), then 100 random dual reads.
  - Required: rs1_data and rs2_data equal register_array at their addresses; entry 0 always reads 0.
